sort4_compare_controller: RTL and testbench

- Sequencer that shares a single instance of the team's three_bit_comparator module across a 4-entry register bank of 3-bit values.
- Accepts four values through a valid/ready input stream and bubble-sorts them in place, one compare-and-swap per clock.
- Streams the sorted result out through a valid/ready output stream.
- Sits between the combinational comparator datapath and any consumer that needs ordered 3-bit keys, such as priority or ranking logic.

---
 rtl/sort4_compare_controller_if.sv | 24 ++
 rtl/sort4_compare_controller.sv | 194 +++++++++++++++++++
 tb/tb_sort4_compare_controller.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort4_compare_controller_if.sv
// Input and output key streams of the 4-entry comparator sort sequencer.
// Latency: none; plain wires grouping the two valid/ready streams.
// Backpressure: in_ready from the sorter, out_ready from the consumer.
interface sort4_compare_controller_if;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_data;
    logic       out_last;

    // Producer/consumer side: drives keys in, accepts sorted keys out.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    // Sorter side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/sort4_compare_controller.sv
// Magnitude comparator for two unsigned 3-bit keys.
// Latency: combinational.
// Backpressure: none.
module three_bit_comparator (
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic       gt,
    output logic       eq,
    output logic       lt
);
    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);
endmodule

// Bubble-sorts four 3-bit keys in place with one shared comparator, one compare-and-swap per clock.
// Latency: 4th input accept to first out_valid is 4, 7 or 10 cycles (3/6/9 SORT cycles plus one edge).
// Backpressure: in_ready only in LOAD; out_data/out_last hold while out_ready is low; flush beats handshakes.
module sort4_compare_controller #(
    parameter bit DESCENDING = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    sort4_compare_controller_if.slave bus,
    output logic                      busy,
    output logic [2:0]                swap_count,
    output logic [1:0]                pass_count
);
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SORT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0][2:0] mem_q, mem_d;
    logic [1:0]      wr_idx_q, wr_idx_d;
    logic [1:0]      rd_idx_q, rd_idx_d;
    logic [1:0]      step_q, step_d;
    logic [1:0]      pass_q, pass_d;
    logic            pass_swapped_q, pass_swapped_d;
    logic [2:0]      swap_count_q, swap_count_d;
    logic [1:0]      pass_count_q, pass_count_d;

    logic [1:0]      step_nxt;
    logic            cmp_gt, cmp_eq, cmp_lt;
    logic            do_swap, last_step, sort_done;
    logic            st_load, st_sort, st_out;
    logic            in_acc, out_acc;

    assign st_load  = (state_q == ST_LOAD);
    assign st_sort  = (state_q == ST_SORT);
    assign st_out   = (state_q == ST_OUT);
    assign step_nxt = step_q + 2'd1;

    three_bit_comparator u_cmp (
        .a  (mem_q[step_q]),
        .b  (mem_q[step_nxt]),
        .gt (cmp_gt),
        .eq (cmp_eq),
        .lt (cmp_lt)
    );

    // Equal keys never swap, which keeps the sort stable in both directions.
    assign do_swap   = st_sort & ~cmp_eq & (DESCENDING ? cmp_lt : cmp_gt);
    assign last_step = (step_q == 2'd2);
    // A pass ends the sort when it made no swap at all, or when it was the third pass.
    assign sort_done = st_sort & last_step & (~(pass_swapped_q | do_swap) | (pass_q == 2'd2));
    assign in_acc    = st_load & bus.in_valid;
    assign out_acc   = st_out & bus.out_ready;

    // State register; reset drops any in-flight data straight back to LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: if (in_acc && (wr_idx_q == 2'd3)) state_d = ST_SORT;
                ST_SORT: if (sort_done) state_d = ST_OUT;
                ST_OUT:  if (out_acc && (rd_idx_q == 2'd3)) state_d = ST_LOAD;
                default: state_d = ST_LOAD;
            endcase
        end
    end

    // Outputs decoded from the current state only, so they drop as soon as reset asserts.
    always_comb begin
        bus.in_ready  = st_load;
        bus.out_valid = st_out;
        bus.out_last  = st_out & (rd_idx_q == 2'd3);
        bus.out_data  = mem_q[rd_idx_q];
        busy          = st_sort;
    end

    assign swap_count = swap_count_q;
    assign pass_count = pass_count_q;

    // Next values of the register bank, indices and sort statistics.
    always_comb begin
        mem_d          = mem_q;
        wr_idx_d       = wr_idx_q;
        rd_idx_d       = rd_idx_q;
        step_d         = step_q;
        pass_d         = pass_q;
        pass_swapped_d = pass_swapped_q;
        swap_count_d   = swap_count_q;
        pass_count_d   = pass_count_q;
        if (flush) begin
            wr_idx_d       = 2'd0;
            rd_idx_d       = 2'd0;
            step_d         = 2'd0;
            pass_d         = 2'd0;
            pass_swapped_d = 1'b0;
            swap_count_d   = 3'd0;
            pass_count_d   = 2'd0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (in_acc) begin
                        mem_d[wr_idx_q] = bus.in_data;
                        if (wr_idx_q == 2'd3) begin
                            // Statistics restart here so they describe the sort about to run.
                            wr_idx_d       = 2'd0;
                            step_d         = 2'd0;
                            pass_d         = 2'd0;
                            pass_swapped_d = 1'b0;
                            swap_count_d   = 3'd0;
                            pass_count_d   = 2'd0;
                        end else begin
                            wr_idx_d = wr_idx_q + 2'd1;
                        end
                    end
                end
                ST_SORT: begin
                    if (do_swap) begin
                        mem_d[step_q]   = mem_q[step_nxt];
                        mem_d[step_nxt] = mem_q[step_q];
                        swap_count_d    = swap_count_q + 3'd1;
                        pass_swapped_d  = 1'b1;
                    end
                    if (last_step) begin
                        pass_count_d = pass_count_q + 2'd1;
                        step_d       = 2'd0;
                        if (!sort_done) begin
                            pass_d         = pass_q + 2'd1;
                            pass_swapped_d = 1'b0;
                        end
                    end else begin
                        step_d = step_nxt;
                    end
                end
                ST_OUT: begin
                    // rd_idx wraps 3 -> 0 on the final beat.
                    if (out_acc) rd_idx_d = rd_idx_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q          <= '0;
            wr_idx_q       <= 2'd0;
            rd_idx_q       <= 2'd0;
            step_q         <= 2'd0;
            pass_q         <= 2'd0;
            pass_swapped_q <= 1'b0;
            swap_count_q   <= 3'd0;
            pass_count_q   <= 2'd0;
        end else begin
            mem_q          <= mem_d;
            wr_idx_q       <= wr_idx_d;
            rd_idx_q       <= rd_idx_d;
            step_q         <= step_d;
            pass_q         <= pass_d;
            pass_swapped_q <= pass_swapped_d;
            swap_count_q   <= swap_count_d;
            pass_count_q   <= pass_count_d;
        end
    end
endmodule

// File: tb/tb_sort4_compare_controller.sv
// Bench for the 4-key sorter: an ascending and a descending instance driven in lockstep.
// Latency: a phase-level model predicts every cycle; directed cases pin results by hand.
// Backpressure: out_ready held, stalled and toggled to exercise output stability.
module tb_sort4_compare_controller;
    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic [2:0] in_data;
    logic       out_ready;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    sort4_compare_controller_if bus0 ();
    sort4_compare_controller_if bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_data   = in_data;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_data   = in_data;
    assign bus1.out_ready = out_ready;

    logic [1:0]      v_in_ready, v_out_valid, v_out_last, v_busy;
    logic [1:0][2:0] v_out_data, v_swap;
    logic [1:0][1:0] v_pass;

    assign v_in_ready  = {bus1.in_ready, bus0.in_ready};
    assign v_out_valid = {bus1.out_valid, bus0.out_valid};
    assign v_out_last  = {bus1.out_last, bus0.out_last};
    assign v_out_data  = {bus1.out_data, bus0.out_data};

    sort4_compare_controller #(.DESCENDING(1'b0)) u_dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (bus0),
        .busy       (v_busy[0]),
        .swap_count (v_swap[0]),
        .pass_count (v_pass[0])
    );

    sort4_compare_controller #(.DESCENDING(1'b1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (bus1),
        .busy       (v_busy[1]),
        .swap_count (v_swap[1]),
        .pass_count (v_pass[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference bubble sort with early exit after a swap-free pass, at most three passes.
    function automatic void bsort(input bit desc, input logic [3:0][2:0] vin,
                                  output logic [3:0][2:0] v, output int sw, output int ps);
        logic [2:0] t;
        bit any;
        v = vin; sw = 0; ps = 0;
        for (int p = 0; p < 3; p++) begin
            any = 0;
            for (int s = 0; s < 3; s++) begin
                if (desc ? (v[s] < v[s+1]) : (v[s] > v[s+1])) begin
                    t = v[s]; v[s] = v[s+1]; v[s+1] = t;
                    sw++; any = 1;
                end
            end
            ps = p + 1;
            if (!any) break;
        end
    endfunction

    // Phase model: 0 = collecting, 1 = sorting for 3*passes cycles, 2 = emitting.
    int              m_phase [2];
    int              m_cnt   [2];
    int              m_rd    [2];
    int              m_left  [2];
    int              m_sw    [2];
    int              m_ps    [2];
    logic [3:0][2:0] m_buf   [2];
    logic [3:0][2:0] m_sorted[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_phase[d] = 0; m_cnt[d] = 0; m_rd[d] = 0;
                m_left[d] = 0; m_sw[d] = 0; m_ps[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (flush) begin
                    m_phase[d] = 0; m_cnt[d] = 0; m_rd[d] = 0; m_sw[d] = 0; m_ps[d] = 0;
                end else begin
                    case (m_phase[d])
                        0: if (in_valid) begin
                            m_buf[d][m_cnt[d]] = in_data;
                            m_cnt[d]++;
                            if (m_cnt[d] == 4) begin
                                bsort(d == 1, m_buf[d], m_sorted[d], m_sw[d], m_ps[d]);
                                m_left[d]  = 3 * m_ps[d];
                                m_phase[d] = 1;
                                m_cnt[d]   = 0;
                            end
                        end
                        1: begin
                            m_left[d]--;
                            if (m_left[d] == 0) begin
                                m_phase[d] = 2;
                                m_rd[d]    = 0;
                            end
                        end
                        default: if (out_ready) begin
                            if (m_rd[d] == 3) m_phase[d] = 0;
                            else m_rd[d]++;
                        end
                    endcase
                end
            end
        end
    end

    int got0[$];
    int got1[$];
    int acc_cyc [2] = '{0, 0};
    int lat     [2] = '{0, 0};
    bit wait_lat[2] = '{0, 0};

    // Per-cycle comparison against the model, plus output capture and latency measurement.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("in_ready%0d", d), int'(v_in_ready[d]), int'(m_phase[d] == 0));
                chk($sformatf("out_valid%0d", d), int'(v_out_valid[d]), int'(m_phase[d] == 2));
                chk($sformatf("busy%0d", d), int'(v_busy[d]), int'(m_phase[d] == 1));
                if (m_phase[d] == 2) begin
                    chk($sformatf("out_data%0d", d), int'(v_out_data[d]), int'(m_sorted[d][m_rd[d]]));
                    chk($sformatf("out_last%0d", d), int'(v_out_last[d]), int'(m_rd[d] == 3));
                end else begin
                    chk($sformatf("out_last_idle%0d", d), int'(v_out_last[d]), 0);
                end
                if (m_phase[d] != 1) begin
                    chk($sformatf("swap_count%0d", d), int'(v_swap[d]), m_sw[d]);
                    chk($sformatf("pass_count%0d", d), int'(v_pass[d]), m_ps[d]);
                end
                if (!flush && m_phase[d] == 0 && m_cnt[d] == 3 && in_valid) begin
                    acc_cyc[d]  = cyc;
                    wait_lat[d] = 1;
                end else if (wait_lat[d] && v_out_valid[d]) begin
                    lat[d]      = cyc - acc_cyc[d];
                    wait_lat[d] = 0;
                end
                if (!flush && v_out_valid[d] && out_ready) begin
                    if (d == 0) got0.push_back(int'(v_out_data[0]));
                    else        got1.push_back(int'(v_out_data[1]));
                end
            end
        end
    end

    task automatic wait_load(input string nm);
        int n;
        n = 0;
        while (v_in_ready != 2'b11 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk({"timeout_", nm}, int'(n < 300), 1);
    endtask

    task automatic load4(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic [2:0] e);
        logic [3:0][2:0] v;
        v = {e, c, b, a};
        wait_load("load");
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        out_ready = 1'b1;
        wait_load(nm);
        out_ready = 1'b0;
    endtask

    task automatic chk_seq(input string nm, input int d, input int base,
                           input int e0, input int e1, input int e2, input int e3);
        int n, act, exp;
        n = (d == 0) ? got0.size() : got1.size();
        chk({nm, "_count"}, n - base, 4);
        if (n - base == 4) begin
            act = 0;
            for (int i = 0; i < 4; i++)
                act = act * 8 + ((d == 0) ? got0[base + i] : got1[base + i]);
            exp = ((e0 * 8 + e1) * 8 + e2) * 8 + e3;
            chk({nm, "_order_octal"}, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, b1, n;
        bit last_acc, rise_seen, rdy;
        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 3'd0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_in_ready", int'(v_in_ready), 3);
        chk("rst_out_valid", int'(v_out_valid), 0);
        chk("rst_busy", int'(v_busy), 0);
        chk("rst_out_data", int'(v_out_data[0]), 0);
        chk("rst_out_last", int'(v_out_last), 0);
        chk("rst_swap_count", int'(v_swap[0]), 0);
        chk("rst_pass_count", int'(v_pass[0]), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Already sorted: one pass, no swaps.
        b0 = got0.size(); b1 = got1.size();
        load4(3'd1, 3'd3, 3'd5, 3'd7); drain("a");
        chk_seq("a_asc", 0, b0, 1, 3, 5, 7);
        chk_seq("a_desc", 1, b1, 7, 5, 3, 1);
        chk("a_swaps", int'(v_swap[0]), 0);
        chk("a_passes", int'(v_pass[0]), 1);
        chk("a_latency", lat[0], 4);
        chk("a_desc_swaps", int'(v_swap[1]), 6);

        // Reversed: worst case for ascending.
        b0 = got0.size(); b1 = got1.size();
        load4(3'd7, 3'd5, 3'd3, 3'd1); drain("b");
        chk_seq("b_asc", 0, b0, 1, 3, 5, 7);
        chk_seq("b_desc", 1, b1, 7, 5, 3, 1);
        chk("b_swaps", int'(v_swap[0]), 6);
        chk("b_passes", int'(v_pass[0]), 3);
        chk("b_latency", lat[0], 10);
        chk("b_desc_passes", int'(v_pass[1]), 1);

        // Duplicate keys never swap with each other.
        b0 = got0.size(); b1 = got1.size();
        load4(3'd4, 3'd4, 3'd2, 3'd4); drain("c");
        chk_seq("c_asc", 0, b0, 2, 4, 4, 4);
        chk_seq("c_desc", 1, b1, 4, 4, 4, 2);
        chk("c_swaps", int'(v_swap[0]), 2);
        chk("c_desc_swaps", int'(v_swap[1]), 1);

        // Descending instance with a zero key and a tie.
        b0 = got0.size(); b1 = got1.size();
        load4(3'd0, 3'd6, 3'd6, 3'd3); drain("d");
        chk_seq("d_desc", 1, b1, 6, 6, 3, 0);
        chk_seq("d_asc", 0, b0, 0, 3, 6, 6);
        chk("d_desc_swaps", int'(v_swap[1]), 3);
        chk("d_desc_passes", int'(v_pass[1]), 2);
        chk("d_desc_latency", lat[1], 7);

        // Output stall then toggling consumer.
        b0 = got0.size(); b1 = got1.size();
        load4(3'd2, 3'd0, 3'd1, 3'd3);
        n = 0;
        while (!bus0.out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("e_wait_out", int'(n < 50), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("e_stall_valid", int'(v_out_valid[0]), 1);
            chk("e_stall_data", int'(v_out_data[0]), 0);
            @(posedge clk); #1;
        end
        rdy = 1'b1; rise_seen = 1'b0; n = 0;
        while (v_in_ready != 2'b11 && n < 60) begin
            out_ready = rdy; rdy = !rdy;
            @(negedge clk);
            last_acc = v_out_valid[0] && out_ready && v_out_last[0];
            @(posedge clk); #1;
            if (last_acc) begin
                chk("e_in_ready_rise", int'(v_in_ready[0]), 1);
                rise_seen = 1'b1;
            end
            n++;
        end
        out_ready = 1'b0;
        chk("e_toggle_done", int'(n < 60), 1);
        chk("e_rise_seen", int'(rise_seen), 1);
        chk_seq("e_asc", 0, b0, 0, 1, 2, 3);
        chk_seq("e_desc", 1, b1, 3, 2, 1, 0);

        // Flush during SORT, step 1 of the first pass (after one swap already made).
        load4(3'd5, 3'd4, 3'd3, 3'd2);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("f_busy", int'(v_busy[0]), 0);
        chk("f_in_ready", int'(v_in_ready), 3);
        chk("f_swap_count", int'(v_swap[0]), 0);
        b0 = got0.size(); b1 = got1.size();
        load4(3'd6, 3'd1, 3'd2, 3'd0); drain("f");
        chk_seq("f_asc", 0, b0, 0, 1, 2, 6);
        chk_seq("f_desc", 1, b1, 6, 2, 1, 0);
        chk("f_swaps", int'(v_swap[0]), 5);

        // Flush in the same cycle as an input beat: beat dropped, write index restarts.
        in_valid = 1'b1; in_data = 3'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1; in_data = 3'd5;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("g_in_ready", int'(v_in_ready), 3);
        b0 = got0.size(); b1 = got1.size();
        load4(3'd6, 3'd1, 3'd2, 3'd0); drain("g");
        chk_seq("g_asc", 0, b0, 0, 1, 2, 6);
        chk_seq("g_desc", 1, b1, 6, 2, 1, 0);

        // Asynchronous reset in the middle of OUT.
        load4(3'd6, 3'd1, 3'd2, 3'd0);
        n = 0;
        while (!bus0.out_valid && n < 50) begin @(posedge clk); #1; n++; end
        chk("h_wait_out", int'(n < 50), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("h_async_out_valid", int'(v_out_valid), 0);
        chk("h_async_in_ready", int'(v_in_ready), 3);
        @(posedge clk); #1;
        rst_n = 1'b1;
        b0 = got0.size(); b1 = got1.size();
        load4(3'd6, 3'd1, 3'd2, 3'd0); drain("h");
        chk_seq("h_asc", 0, b0, 0, 1, 2, 6);
        chk_seq("h_desc", 1, b1, 6, 2, 1, 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
